// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware FIFO with SOP tagging, length tracking, occupancy and sticky error status
module router_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              lfd_state,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              rd_sop,
  output logic              pkt_last,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              frame_err
);
  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [DATA_W-2:0] rem;
  logic [DATA_W:0]   rd_word;
  logic              do_wr, do_rd, rd_is_sop;
  assign empty       = wr_ptr == rd_ptr;
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = level >= (ADDR_W+1)'(AF_THRESH);
  assign do_wr       = write_enb && !full;
  assign do_rd       = read_enb && !empty;
  assign rd_word     = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_is_sop   = rd_word[DATA_W];
  always_ff @(posedge clk)
    if (resetn && !soft_reset && do_wr) mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rem        <= '0;
      data_out   <= '0;
      rd_sop     <= 1'b0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rem        <= '0;
      data_out   <= '0;
      rd_sop     <= 1'b0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (write_enb && full) ovf_err <= 1'b1;
      if (read_enb && empty) udf_err <= 1'b1;
      data_valid <= do_rd;
      pkt_last   <= do_rd && !rd_is_sop && rem == (DATA_W-1)'(1);
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word[DATA_W-1:0];
        rd_sop   <= rd_is_sop;
        // a header reloads the count with payload plus parity; a reload mid-packet means truncation
        if (rd_is_sop) begin
          rem <= {1'b0, rd_word[DATA_W-1:2]} + 1'b1;
          if (rem != '0) frame_err <= 1'b1;
        end else if (rem != '0) begin
          rem <= rem - 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised packet-aware FIFO for the router output channels, successor to the fixed 8-bit x 16 channel FIFO. Each entry stores a data word plus a start-of-packet (SOP) marker. The read side decodes the payload length from each header and tracks the bytes remaining in the current packet. It reports occupancy, almost-full, end-of-packet and sticky error status to the router FSM and synchroniser.

## Interface
- DATA_W, 8: data word width; header bits [DATA_W-1:2] carry the payload length.
- DEPTH, 16: entries; must be a power of two and at least 4. ADDR_W = log2(DEPTH).
- AF_THRESH, DEPTH-2: level at or above which almost_full asserts.

- clk  in  1  clock, all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- soft_reset  in  1  synchronous flush, e.g. on a synchroniser timeout.
- write_enb  in  1  write request.
- data_in  in  DATA_W  write data.
- lfd_state  in  1  SOP marker, aligned with data_in in the same cycle.
- read_enb  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out was loaded on the last edge.
- rd_sop  out  1  SOP marker of the word on data_out.
- pkt_last  out  1  word on data_out is the final (parity) byte of its packet.
- empty  out  1  level == 0 (combinational from pointers).
- full  out  1  level == DEPTH (combinational from pointers).
- almost_full  out  1  level >= AF_THRESH.
- level  out  ADDR_W+1  current occupancy.
- ovf_err  out  1  sticky: write attempted while full.
- udf_err  out  1  sticky: read attempted while empty.
- frame_err  out  1  sticky: non-SOP word read while no packet is open.

## Operation
- Storage: DEPTH x (DATA_W+1) array. Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Write: on write_enb && !full, store {lfd_state, data_in} at wr_ptr and increment wr_ptr.
- Read: on read_enb && !empty, load data_out/rd_sop from rd_ptr, increment rd_ptr and set data_valid=1. Otherwise data_valid=0 and data_out/rd_sop hold their values.
- Remaining counter rem (DATA_W-1 bits):
  - SOP word read: rem <= header[DATA_W-1:2] + 1 (payload plus parity).
  - Non-SOP word read with rem != 0: rem <= rem - 1.
  - pkt_last = 1 when a non-SOP read takes rem from 1 to 0. A header with length 0 followed by a single read gives pkt_last on that read.
  - Non-SOP read with rem == 0: word is still delivered and frame_err is set.
  - SOP read with rem != 0 (truncated packet): rem reloads and frame_err is set.
- level: +1 on a write only, -1 on a read only, unchanged when both or neither occur.
- Simultaneous read and write:
  - When full: the read proceeds and the write is blocked; ovf_err is set.
  - When empty: the write proceeds and the read is blocked; udf_err is set. No bypass.
- Priority: resetn, then soft_reset, then normal operation.
- resetn low: pointers, level, rem, data_out, rd_sop, data_valid, pkt_last and all error flags go to 0. Memory contents are don't-care.
- soft_reset high: pointers, level, rem, data_valid, pkt_last and rd_sop go to 0. data_out is set to 0. Error flags are retained. Any write or read in that cycle is ignored.

## Timing
- Read latency is 1 cycle: request at edge N, and data_out/data_valid/rd_sop/pkt_last are valid after edge N for one cycle.
- Write-to-read: a word written at edge N clears empty after edge N and can be read at edge N+1.
- full, empty, almost_full and level reflect the pointers after each edge. No registered lag.
- Error flags set on the edge of the offending request.
- Reset mid-packet: after soft_reset, the next read must be a SOP word or frame_err sets.
- Wrap-around: pointers wrap modulo 2*DEPTH. full/empty must remain correct across any number of wraps.

## Test plan
- Reset: resetn=0 for 2 cycles → empty=1, full=0, level=0, data_out=0x00, all error flags 0.
- Packet flow, DATA_W=8: write header 0x0C with SOP, then 3 payload bytes and 1 parity byte; read 5 words → rd_sop=1 on the first, pkt_last=1 only on the 5th, level returns to 0.
- Full/overflow, DEPTH=16: write 16 words → full=1, almost_full=1 from level 14. A 17th write is dropped, ovf_err=1, level stays 16.
- Simultaneous read and write at level 16 → level goes to 15, write dropped. At level 0 → level goes to 1, udf_err=1, data_valid=0.
- Wrap: stream 40 single-word packets (header 0x00, one parity byte), keeping level at or below 3 → data order preserved, no errors, pointers wrap at least twice.
- soft_reset after 2 of 5 packet bytes are read → empty=1 and rem=0. The next non-SOP read sets frame_err, while ovf_err and udf_err keep their prior values.
